// File: rtl/bitpat_scan_ctrl.sv
// bitpat_scan_ctrl: loads pages, strobes matcher per block, drains true page numbers.
// Optional tpn_count output enabled by defining TPN_COUNT_EN.
module bitpat_scan_ctrl #(
  parameter int ARR_SIZE  = 288,
  parameter int P_SIZE    = 12,
  parameter int NOB       = 3,
  parameter int NOP_WIDTH = 5,
  parameter int NOB_WIDTH = 2,
  parameter int WAIT_CYC  = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pg_valid,
  output logic                              pg_ready,
  input  logic [P_SIZE-1:0]                 pg_data,
  input  logic [P_SIZE-1:0]                 pat1,
  input  logic [P_SIZE-1:0]                 pat2,
  input  logic [P_SIZE-1:0]                 pat3,
  input  logic [P_SIZE-1:0]                 pat4,
  output logic [ARR_SIZE-1:0]               a,
  output logic [P_SIZE-1:0]                 x1,
  output logic [P_SIZE-1:0]                 x2,
  output logic [P_SIZE-1:0]                 x3,
  output logic [P_SIZE-1:0]                 x4,
  output logic [NOB_WIDTH:0]                b_idx,
  output logic                              put_global_array,
  input  logic [NOP_WIDTH*(ARR_SIZE/P_SIZE)-1:0] g_tpn_arr,
  output logic                              tpn_valid,
  input  logic                              tpn_ready,
  output logic [NOP_WIDTH-1:0]              tpn_data,
  output logic                              tpn_last,
  output logic                              scan_done
`ifdef TPN_COUNT_EN
  ,
  output logic [NOP_WIDTH:0]                tpn_count
`endif
);
  localparam int NOP = ARR_SIZE / P_SIZE;
  localparam logic [NOP_WIDTH-1:0] SENT = '1;
  localparam logic [NOP_WIDTH-1:0] PC_LAST = NOP_WIDTH'(NOP - 1);
  localparam logic [NOB_WIDTH:0] B_LAST = (NOB_WIDTH+1)'(NOB - 1);
  typedef enum logic [2:0] {LOAD, PUT, WAIT, FINAL, FWAIT, CAPTURE, DRAIN} state_t;
  state_t state, nstate;
  logic [NOP_WIDTH-1:0] pc, e, cur, nxt;
  logic [7:0] wc;
  logic wc_end, hs;
  logic [NOP_WIDTH*NOP-1:0] cap;
  logic [NOP_WIDTH*(NOP+2)-1:0] capx;
  // Two trailing sentinels let e and e+1 index past the last entry without a range guard.
  assign capx = {{(2*NOP_WIDTH){1'b1}}, cap};
  assign cur = capx[e*NOP_WIDTH +: NOP_WIDTH];
  assign nxt = capx[(int'(e)+1)*NOP_WIDTH +: NOP_WIDTH];
  assign wc_end = wc == 8'(WAIT_CYC - 1);
  assign hs = tpn_valid && tpn_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= LOAD;
    else state <= nstate;
  always_comb begin
    nstate = state;
    case (state)
      LOAD:    nstate = (pg_valid && pc == PC_LAST) ? PUT : LOAD;
      PUT:     nstate = WAIT;
      WAIT:    nstate = !wc_end ? WAIT : (b_idx < B_LAST) ? PUT : FINAL;
      FINAL:   nstate = FWAIT;
      FWAIT:   nstate = wc_end ? CAPTURE : FWAIT;
      CAPTURE: nstate = DRAIN;
      DRAIN:   nstate = (cur == SENT) ? LOAD : DRAIN;
      default: nstate = LOAD;
    endcase
  end
  always_comb begin
    pg_ready = state == LOAD;
    put_global_array = state == PUT || state == FINAL;
    tpn_valid = state == DRAIN && cur != SENT;
    tpn_data = cur;
    tpn_last = tpn_valid && nxt == SENT;
    scan_done = state == DRAIN && cur == SENT;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a <= '0;
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
      x4 <= '0;
      b_idx <= '0;
      pc <= '0;
      wc <= '0;
      e <= '0;
      cap <= '0;
    end else begin
      wc <= ((state == WAIT || state == FWAIT) && !wc_end) ? wc + 1'b1 : '0;
      if (state == LOAD) begin
        b_idx <= '0;
        if (pg_valid) begin
          a[pc*P_SIZE +: P_SIZE] <= pg_data;
          pc <= (pc == PC_LAST) ? '0 : pc + 1'b1;
          if (pc == '0) begin
            x1 <= pat1;
            x2 <= pat2;
            x3 <= pat3;
            x4 <= pat4;
          end
        end
      end
      if (state == WAIT && wc_end && b_idx < B_LAST) b_idx <= b_idx + 1'b1;
      if (state == CAPTURE) begin
        cap <= g_tpn_arr;
        e <= '0;
      end
      if (hs) e <= e + 1'b1;
    end
`ifdef TPN_COUNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) tpn_count <= '0;
    else if (state == CAPTURE) tpn_count <= '0;
    else if (hs) tpn_count <= tpn_count + 1'b1;
`endif
endmodule
